// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port word memory: transfer size encoding,
// byte-lane helpers and load extension.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } tsize_e;

  localparam int MEM_LAT_MAX = 2;

  function automatic logic [3:0] be_from_tsize(input tsize_e tsize, input logic [1:0] off);
    logic [3:0] be;
    case (tsize)
      BYTE:     be = 4'b0001 << off;
      HALFWORD: be = 4'b0011 << off;
      WORD:     be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_aligned(input tsize_e tsize, input logic [1:0] off);
    logic ok;
    case (tsize)
      BYTE:     ok = 1'b1;
      HALFWORD: ok = (off[0] == 1'b0);
      WORD:     ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Store data arrives right-justified; copy it into every lane so the
  // byte enables alone pick the destination.
  function automatic logic [31:0] replicate_wdata(input tsize_e tsize, input logic [31:0] wdata);
    logic [31:0] rep;
    case (tsize)
      BYTE:     rep = {4{wdata[7:0]}};
      HALFWORD: rep = {2{wdata[15:0]}};
      default:  rep = wdata;
    endcase
    return rep;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input tsize_e      tsize,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (tsize)
      BYTE:     res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      HALFWORD: res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      WORD:     res = word;
      default:  res = 32'h00000000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Response delay line: LATENCY stages of valid/data/err, cleared synchronously.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [W-1:0]       data_q [LATENCY];

  // Shift the response through the stages; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      data_q[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/memory_word_dp.sv
// Dual-port word memory: port A load/store with byte lanes, port B word fetch.
// Define MEM_WRITE_FORWARD_EN to forward same-cycle port A stores to port B.
module memory_word_dp
  import mem_pkg::*;
#(
  parameter int N         = 4096,
  parameter int LATENCY   = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [$clog2(N)-1:0] a_addr,
  input  tsize_e               a_tsize,
  input  logic                 a_unsigned,
  input  logic [31:0]          a_wdata,
  output logic                 a_ready,
  output logic                 a_rvalid,
  output logic [31:0]          a_rdata,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic [$clog2(N)-1:0] b_addr,
  output logic                 b_rvalid,
  output logic [31:0]          b_rdata,
  output logic                 b_err
);

  localparam int AW    = $clog2(N);
  localparam int WORDS = N / 4;

  if (LATENCY < 1 || LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("memory_word_dp: LATENCY must be 1 or 2");
  end
  if (N < 8 || (N & (N - 1)) != 0) begin : g_bad_size
    $error("memory_word_dp: N must be a power of two, at least 8");
  end
  // Time-zero contents come from the simulator's initial state of the array.
  if (INIT_ZERO != 0 && INIT_ZERO != 1) begin : g_bad_init
    $error("memory_word_dp: INIT_ZERO must be 0 or 1");
  end

  logic [31:0]   mem [WORDS];

  logic [AW-3:0] a_idx;
  logic [AW-3:0] b_idx;
  logic          a_acc;
  logic          a_ok;
  logic          a_wr;
  logic [3:0]    a_be;
  logic [31:0]   a_rep;
  logic [31:0]   a_word;
  logic [31:0]   a_resp_data;
  logic          a_resp_err;
  logic          b_acc;
  logic          b_ok;
  logic [31:0]   b_word;
  logic [31:0]   b_resp_data;

  assign a_ready = !rst;

  // Port A decode: alignment, lane enables and the load result.
  always_comb begin
    a_idx       = a_addr[AW-1:2];
    a_acc       = a_req && !rst;
    a_ok        = is_aligned(a_tsize, a_addr[1:0]);
    a_wr        = a_acc && a_we && a_ok;
    a_be        = be_from_tsize(a_tsize, a_addr[1:0]);
    a_rep       = replicate_wdata(a_tsize, a_wdata);
    a_word      = mem[a_idx];
    a_resp_err  = a_acc && !a_ok;
    a_resp_data = (a_acc && !a_we && a_ok) ?
                  load_extend(a_word, a_tsize, a_addr[1:0], a_unsigned) : 32'h00000000;
  end

  // Port B fetch, with optional bypass of the store committing this edge.
  always_comb begin
    b_idx = b_addr[AW-1:2];
    b_acc = b_req && !rst;
    b_ok  = (b_addr[1:0] == 2'b00);
`ifdef MEM_WRITE_FORWARD_EN
    b_word = (a_wr && (a_idx == b_idx)) ? merge_lanes(mem[b_idx], a_rep, a_be) : mem[b_idx];
`else
    b_word = mem[b_idx];
`endif
    b_resp_data = (b_acc && b_ok) ? b_word : 32'h00000000;
  end

  // Byte-lane store; contents survive reset.
  always_ff @(posedge clk) begin
    if (a_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) begin
          mem[a_idx][8*i +: 8] <= a_rep[8*i +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(.LATENCY(LATENCY), .W(32)) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_acc),
    .in_data   (a_resp_data),
    .in_err    (a_resp_err),
    .out_valid (a_rvalid),
    .out_data  (a_rdata),
    .out_err   (a_err)
  );

  mem_resp_pipe #(.LATENCY(LATENCY), .W(32)) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_acc),
    .in_data   (b_resp_data),
    .in_err    (b_acc && !b_ok),
    .out_valid (b_rvalid),
    .out_data  (b_rdata),
    .out_err   (b_err)
  );

endmodule
